fft_pingpong_ram: RTL and testbench

Double-buffered complex sample memory that sits between the sample input stream and the FFT core. One bank fills with streaming samples while the FFT core reads and writes the other bank in place. Banks swap under a start/done handshake. An optional bit-reversed write order presents the FFT core with input already in decimation-in-time order.

---
 rtl/fft_pingpong_ram.sv | 113 +++++++++++
 tb/tb_fft_pingpong_ram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_pingpong_ram.sv
// Double-buffered complex sample memory between the input stream and the FFT core.
// One bank fills from the input while the FFT core works in place on the other.
//
// fill_st  | meaning
// FILLING  | fill bank accepting samples (fill_full = 0)
// FULL     | fill bank holds a complete frame, input stalled
// proc_st  | meaning
// IDLE     | no frame owned by the FFT core
// BUSY     | processing bank owned by the FFT core
module fft_pingpong_ram #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9,
  parameter bit BITREV    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*BIT_WIDTH-1:0] in_data,
  output logic                   fft_start,
  output logic                   fft_busy,
  input  logic                   fft_done,
  input  logic                   fft_we,
  input  logic [N-1:0]           fft_add,
  input  logic [2*BIT_WIDTH-1:0] fft_din,
  output logic [2*BIT_WIDTH-1:0] fft_dout,
  output logic                   bank_sel
);

  localparam int W     = 2 * BIT_WIDTH;
  localparam int DEPTH = 1 << N;

  typedef enum logic {FILLING, FULL} fill_state_t;
  typedef enum logic {IDLE, BUSY} proc_state_t;

  fill_state_t  fill_st;
  proc_state_t  proc_st;
  logic [N-1:0] fill_cnt;
  logic [N-1:0] fill_addr;
  logic         fill_full;
  logic         fill_fire;
  logic         swap;

  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];

  assign fill_full = (fill_st == FULL);
  assign fft_busy  = (proc_st == BUSY);
  assign in_ready  = !fill_full;
  assign fill_fire = in_valid && !fill_full;
  // a pending full bank is handed over as soon as the core is free or just finishing
  assign swap      = fill_full && (!fft_busy || fft_done);

  always_comb begin
    fill_addr = fill_cnt;
    if (BITREV) begin
      for (int i = 0; i < N; i++) fill_addr[i] = fill_cnt[N-1-i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_st   <= FILLING;
      proc_st   <= IDLE;
      fill_cnt  <= '0;
      bank_sel  <= 1'b0;
      fft_start <= 1'b0;
    end else begin
      fft_start <= swap;
      if (swap) bank_sel <= !bank_sel;

      case (fill_st)
        FILLING: begin
          if (in_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (&fill_cnt) fill_st <= FULL;
          end
        end
        FULL: begin
          if (swap) fill_st <= FILLING;
        end
        default: fill_st <= FILLING;
      endcase

      case (proc_st)
        IDLE: begin
          if (swap) proc_st <= BUSY;
        end
        BUSY: begin
          if (!swap && fft_done) proc_st <= IDLE;
        end
        default: proc_st <= IDLE;
      endcase
    end
  end

  // The fill write and the FFT write always target different banks.
  always_ff @(posedge clk) begin
    if (!bank_sel && fft_we) mem0[fft_add] <= fft_din;
    else if (bank_sel && fill_fire) mem0[fill_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (bank_sel && fft_we) mem1[fft_add] <= fft_din;
    else if (!bank_sel && fill_fire) mem1[fill_addr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fft_dout <= '0;
    else       fft_dout <= bank_sel ? mem1[fft_add] : mem0[fft_add];
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram: natural-order instance plus a bit-reversed
// instance, read data checked through an expected-value queue.
module tb_fft_pingpong_ram;

  localparam int BW = 16;
  localparam int NB = 3;

  logic          clk;
  logic          reset;

  logic          a_in_valid, a_in_ready, a_fft_start, a_fft_busy, a_fft_done, a_fft_we, a_bank_sel;
  logic [31:0]   a_in_data, a_fft_din, a_fft_dout;
  logic [NB-1:0] a_fft_add;

  logic          b_in_valid, b_in_ready, b_fft_start, b_fft_busy, b_fft_done, b_fft_we, b_bank_sel;
  logic [31:0]   b_in_data, b_fft_din, b_fft_dout;
  logic [NB-1:0] b_fft_add;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [2][8];
  int          m_bank;
  int          m_cnt;
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [31:0] exp_v;

  int b_addr [4] = '{1, 3, 6, 7};
  int b_exp  [4] = '{4, 6, 3, 7};

  fft_pingpong_ram #(.BIT_WIDTH(BW), .N(NB), .BITREV(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .fft_start(a_fft_start), .fft_busy(a_fft_busy), .fft_done(a_fft_done),
    .fft_we(a_fft_we), .fft_add(a_fft_add), .fft_din(a_fft_din),
    .fft_dout(a_fft_dout), .bank_sel(a_bank_sel)
  );

  fft_pingpong_ram #(.BIT_WIDTH(BW), .N(NB), .BITREV(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .fft_start(b_fft_start), .fft_busy(b_fft_busy), .fft_done(b_fft_done),
    .fft_we(b_fft_we), .fft_add(b_fft_add), .fft_din(b_fft_din),
    .fft_dout(b_fft_dout), .bank_sel(b_bank_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
    check({tag, "_start"},    32'(a_fft_start), 32'd0);
    check({tag, "_busy"},     32'(a_fft_busy), 32'd0);
    check({tag, "_bank_sel"}, 32'(a_bank_sel), 32'd0);
    check({tag, "_dout"},     a_fft_dout, 32'd0);
  endtask

  // one accepted sample on instance a; the model tracks where it must land
  task automatic fill_a(input logic [31:0] d);
    check("fill_in_ready", 32'(a_in_ready), 32'd1);
    a_in_valid = 1'b1;
    a_in_data  = d;
    m_mem[1 - m_bank][m_cnt] = d;
    m_cnt = (m_cnt + 1) % 8;
    tick();
  endtask

  task automatic read_a(input int addr, input string tag);
    a_fft_add = NB'(addr);
    a_q.push_back(m_mem[m_bank][addr]);
    tick();
    exp_v = a_q.pop_front();
    check(tag, a_fft_dout, exp_v);
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_fft_done = 0; a_fft_we = 0; a_fft_add = '0; a_fft_din = '0;
    b_in_valid = 0; b_in_data = '0; b_fft_done = 0; b_fft_we = 0; b_fft_add = '0; b_fft_din = '0;
    m_bank = 0;
    m_cnt  = 0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // frame 1: samples 0..7 on consecutive cycles, both instances
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'(i);
      fill_a(32'(i));
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    check("f1_ready_drop", 32'(a_in_ready), 32'd0);
    check("f1_pre_bank",   32'(a_bank_sel), 32'd0);
    check("f1_pre_start",  32'(a_fft_start), 32'd0);
    tick();
    m_bank = 1;
    check("f1_bank",     32'(a_bank_sel), 32'd1);
    check("f1_start",    32'(a_fft_start), 32'd1);
    check("f1_busy",     32'(a_fft_busy), 32'd1);
    check("f1_ready_up", 32'(a_in_ready), 32'd1);
    check("b_bank",      32'(b_bank_sel), 32'd1);
    tick();
    check("f1_start_end", 32'(a_fft_start), 32'd0);
    check("f1_busy_hold", 32'(a_fft_busy), 32'd1);

    for (int i = 0; i < 8; i++) read_a(i, "f1_read");

    for (int k = 0; k < 4; k++) begin
      b_fft_add = NB'(b_addr[k]);
      b_q.push_back(32'(b_exp[k]));
      tick();
      exp_v = b_q.pop_front();
      check("bitrev_read", b_fft_dout, exp_v);
    end

    // in-place write, simultaneous read returns old data
    a_fft_we  = 1'b1;
    a_fft_add = NB'(2);
    a_fft_din = 32'hA5A5_5A5A;
    a_q.push_back(m_mem[1][2]);
    tick();
    exp_v = a_q.pop_front();
    check("rdw_old", a_fft_dout, exp_v);
    m_mem[1][2] = 32'hA5A5_5A5A;
    a_fft_we = 1'b0;
    read_a(2, "wr_readback");

    // frame 2 while busy, then a held 9th sample
    for (int i = 0; i < 8; i++) fill_a(32'(100 + i));
    a_in_valid = 1'b1;
    a_in_data  = 32'd108;
    for (int k = 0; k < 4; k++) begin
      check("bp_ready", 32'(a_in_ready), 32'd0);
      check("bp_busy",  32'(a_fft_busy), 32'd1);
      tick();
    end
    a_fft_done = 1'b1;
    tick();
    a_fft_done = 1'b0;
    m_bank = 0;
    check("done_full_busy",  32'(a_fft_busy), 32'd1);
    check("done_full_bank",  32'(a_bank_sel), 32'd0);
    check("done_full_start", 32'(a_fft_start), 32'd1);
    check("done_full_ready", 32'(a_in_ready), 32'd1);
    m_mem[1][0] = 32'd108;
    m_cnt = 1;
    tick();
    a_in_valid = 1'b0;
    check("held_start_end", 32'(a_fft_start), 32'd0);
    check("held_ready",     32'(a_in_ready), 32'd1);
    for (int i = 0; i < 8; i++) read_a(i, "f2_read");

    // frame 3: fft_done on the same edge as the last write
    for (int i = 1; i < 8; i++) begin
      if (i == 7) a_fft_done = 1'b1;
      fill_a(32'(108 + i));
    end
    a_in_valid = 1'b0;
    a_fft_done = 1'b0;
    check("late_busy",  32'(a_fft_busy), 32'd0);
    check("late_ready", 32'(a_in_ready), 32'd0);
    check("late_bank",  32'(a_bank_sel), 32'd0);
    check("late_start", 32'(a_fft_start), 32'd0);
    tick();
    m_bank = 1;
    check("late_swap_bank",  32'(a_bank_sel), 32'd1);
    check("late_swap_busy",  32'(a_fft_busy), 32'd1);
    check("late_swap_start", 32'(a_fft_start), 32'd1);
    for (int i = 0; i < 8; i++) read_a(i, "f3_read");
    a_fft_done = 1'b1;
    tick();
    a_fft_done = 1'b0;
    check("idle_busy", 32'(a_fft_busy), 32'd0);
    check("idle_bank", 32'(a_bank_sel), 32'd1);

    // reset after 5 of 8 samples
    for (int i = 0; i < 5; i++) fill_a(32'(200 + i));
    a_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b0;
    m_bank = 0;
    m_cnt  = 0;
    for (int i = 0; i < 8; i++) fill_a(32'(300 + i));
    a_in_valid = 1'b0;
    check("rf_ready_drop", 32'(a_in_ready), 32'd0);
    tick();
    m_bank = 1;
    check("rf_bank",  32'(a_bank_sel), 32'd1);
    check("rf_start", 32'(a_fft_start), 32'd1);
    check("rf_busy",  32'(a_fft_busy), 32'd1);
    for (int i = 0; i < 8; i++) read_a(i, "rf_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
